// File: rtl/keypad_matrix_emulator.sv
// Keypad-side emulator for the 4x4 row-scan/column-sense interface: holds a requested
// key for a number of complete scan frames, then releases it for a number of frames.
module keypad_matrix_emulator #(
    parameter int PRESS_FRAMES   = 8,
    parameter int RELEASE_FRAMES = 8,
    parameter int TIMEOUT_CLKS   = 100000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Row,
    output logic [3:0] o_Col,
    input  logic       i_Key_Valid,
    input  logic [3:0] i_Key_Code,
    output logic       o_Key_Ready,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Timeout
);

    localparam int              CW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]      PRESS_LAST = 8'(PRESS_FRAMES - 1);
    localparam logic [7:0]      REL_LAST   = 8'(RELEASE_FRAMES - 1);
    localparam logic [CW-1:0]   TMO_LAST   = CW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]      ROW0       = 4'b1110;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    code, code_nxt;
    logic [3:0]    prev_row;
    logic [7:0]    fcnt, fcnt_nxt;
    logic          armed, armed_nxt;
    logic [CW-1:0] ccnt, ccnt_nxt;
    logic          done_nxt, tmo_nxt;
    logic          frame_start;
    logic [7:0]    frame_last;
    logic [1:0]    key_row, key_col;
    logic [3:0]    row_pat, col_pat;

    // Physical position of the latched key on the matrix
    always_comb begin
        key_row = 2'd3;
        key_col = 2'd1;
        case (code)
            4'h1, 4'h2, 4'h3: begin key_row = 2'd0; key_col = 2'(code - 4'd1); end
            4'hA:             begin key_row = 2'd0; key_col = 2'd3; end
            4'h4, 4'h5, 4'h6: begin key_row = 2'd1; key_col = 2'(code - 4'd4); end
            4'hB:             begin key_row = 2'd1; key_col = 2'd3; end
            4'h7, 4'h8, 4'h9: begin key_row = 2'd2; key_col = 2'(code - 4'd7); end
            4'hC:             begin key_row = 2'd2; key_col = 2'd3; end
            4'hE:             begin key_row = 2'd3; key_col = 2'd0; end
            4'hF:             begin key_row = 2'd3; key_col = 2'd2; end
            4'hD:             begin key_row = 2'd3; key_col = 2'd3; end
            default:          ;
        endcase
    end

    assign row_pat     = ~(4'b0001 << key_row);
    assign col_pat     = ~(4'b0001 << key_col);
    assign o_Col       = (state == PRESS && i_Row == row_pat) ? col_pat : 4'b1111;
    assign o_Busy      = (state != IDLE);
    assign o_Key_Ready = (state == IDLE);
    assign frame_start = (i_Row == ROW0) && (prev_row != ROW0);
    assign frame_last  = (state == PRESS) ? PRESS_LAST : REL_LAST;

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        fcnt_nxt  = fcnt;
        armed_nxt = armed;
        ccnt_nxt  = ccnt;
        done_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_Key_Valid) begin
                    code_nxt  = i_Key_Code;
                    state_nxt = PRESS;
                    fcnt_nxt  = '0;
                    armed_nxt = 1'b0;
                    ccnt_nxt  = '0;
                end
            end
            PRESS, RELEASE: begin
                if (frame_start) begin
                    ccnt_nxt = '0;
                    if (!armed) begin
                        armed_nxt = 1'b1;
                    end else if (fcnt == frame_last) begin
                        fcnt_nxt = '0;
                        if (state == PRESS) begin
                            // entering RELEASE on a frame boundary, so that frame already counts as armed
                            state_nxt = RELEASE;
                            armed_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            armed_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        fcnt_nxt = fcnt + 8'd1;
                    end
                end else if (ccnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 1'b1;
                    fcnt_nxt  = '0;
                    armed_nxt = 1'b0;
                    ccnt_nxt  = '0;
                end else begin
                    ccnt_nxt = ccnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= IDLE;
            code      <= 4'h0;
            prev_row  <= ROW0;
            fcnt      <= '0;
            armed     <= 1'b0;
            ccnt      <= '0;
            o_Done    <= 1'b0;
            o_Timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            prev_row  <= i_Row;
            fcnt      <= fcnt_nxt;
            armed     <= armed_nxt;
            ccnt      <= ccnt_nxt;
            o_Done    <= done_nxt;
            o_Timeout <= tmo_nxt;
        end
    end

endmodule
